// File: rtl/ctrl_pkg.sv
// Shared definitions for the five-stage pipeline sequencing controller.
// Stage indices, pipeline-register count and the redirect state encoding.
package ctrl_pkg;

  localparam int STG_IF    = 0;
  localparam int STG_ID    = 1;
  localparam int STG_EX    = 2;
  localparam int STG_MEM   = 3;
  localparam int STG_WB    = 4;
  localparam int NUM_PREGS = 5;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_stall_wdt.sv
// Stuck-stall watchdog: counts consecutive stalled cycles and raises a sticky
// timeout once STALL_TO cycles in a row have been stalled.
module pipe_stall_wdt #(
  parameter int STALL_TO = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_any,
  output logic timeout
);

  localparam int CW = (STALL_TO > 2) ? $clog2(STALL_TO) : 1;
  localparam logic [CW-1:0] LAST = CW'(STALL_TO - 1);

  logic [CW-1:0] cnt;

  // Counter parks at LAST; the sticky flag carries the event from then on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else if (stall_any) begin
      if (cnt == LAST) begin
        timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges ID/EX/MEM stall requests with EX redirects.
// Optional perf counters are built only when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int STALL_TO = 1024,
  parameter int XLEN     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stallreq_from_id_i,
  input  logic                 stallreq_from_ex_i,
  input  logic                 stallreq_from_mem_i,
  input  logic                 flushreq_from_ex_i,
  input  logic [XLEN-1:0]      flush_target_i,
  output logic [NUM_PREGS-1:0] stall_o,
  output logic [NUM_PREGS-1:0] flush_o,
  output logic                 pc_redirect_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 stall_timeout_o,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          flush_count_o
);

  pipe_ctrl_state_e     state, state_next;
  logic [XLEN-1:0]      pend_pc, pend_next;
  logic [1:0]           stg;
  logic                 can_redirect;
  logic                 redirect;
  logic [NUM_PREGS-1:0] stall_raw, flush_raw;
  logic [XLEN-1:0]      pc_raw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      pend_pc <= pend_next;
    end
  end

  always_comb begin
    stg = 2'd0;
    if (stallreq_from_mem_i)     stg = 2'(STG_MEM);
    else if (stallreq_from_ex_i) stg = 2'(STG_EX);
    else if (stallreq_from_id_i) stg = 2'(STG_ID);

    can_redirect = (stg < 2'(STG_EX));
    redirect     = can_redirect && ((state == PEND) || flushreq_from_ex_i);

    state_next = state;
    pend_next  = pend_pc;
    case (state)
      RUN: begin
        if (flushreq_from_ex_i && !can_redirect) begin
          state_next = PEND;
          pend_next  = flush_target_i;
        end
      end
      PEND: begin
        if (can_redirect) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // A redirect squashes the ID stall: the instruction being held is flushed anyway.
    stall_raw = '0;
    flush_raw = '0;
    pc_raw    = '0;
    if (redirect) begin
      flush_raw = 5'b00110;
      pc_raw    = (state == PEND) ? pend_pc : flush_target_i;
    end else if (stg != 2'd0) begin
      stall_raw = (NUM_PREGS'(2) << stg) - NUM_PREGS'(1);
      flush_raw = NUM_PREGS'(2) << stg;
    end
  end

  assign stall_o       = rst_ni ? stall_raw : '0;
  assign flush_o       = rst_ni ? flush_raw : '0;
  assign pc_redirect_o = rst_ni && redirect;
  assign redirect_pc_o = rst_ni ? pc_raw : '0;

  pipe_stall_wdt #(
    .STALL_TO(STALL_TO)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .stall_any(|stall_o),
    .timeout  (stall_timeout_o)
  );

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (|stall_o)      stall_cycles_o <= stall_cycles_o + 32'd1;
      if (pc_redirect_o) flush_count_o  <= flush_count_o + 32'd1;
    end
  end
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model checked every cycle
// plus directed vectors with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id = 1'b0, ex = 1'b0, mem = 1'b0, fl = 1'b0;
  logic [31:0] tgt = '0;
  logic [4:0]  stall, flush;
  logic        pcr, to;
  logic [31:0] rpc, scyc, fcnt;

  int checks = 0;
  int fails  = 0;

  pipe_ctrl #(.STALL_TO(TO), .XLEN(32)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .stallreq_from_id_i (id),
    .stallreq_from_ex_i (ex),
    .stallreq_from_mem_i(mem),
    .flushreq_from_ex_i (fl),
    .flush_target_i     (tgt),
    .stall_o            (stall),
    .flush_o            (flush),
    .pc_redirect_o      (pcr),
    .redirect_pc_o      (rpc),
    .stall_timeout_o    (to),
    .stall_cycles_o     (scyc),
    .flush_count_o      (fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending redirect slot, consecutive-stall run length, counters.
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_consec;
  bit          m_to;
  logic [31:0] m_sc, m_fc;
  int          s;
  logic [4:0]  e_stall, e_flush;
  logic        e_pcr;
  logic [31:0] e_pc;

  always_comb begin
    s       = mem ? 3 : ex ? 2 : id ? 1 : 0;
    e_stall = '0;
    e_flush = '0;
    e_pcr   = 1'b0;
    e_pc    = '0;
    if (rst_n) begin
      if ((m_pend || fl) && s < 2) begin
        e_pcr   = 1'b1;
        e_flush = 5'b00110;
        e_pc    = m_pend ? m_tgt : tgt;
      end else if (s > 0) begin
        for (int j = 0; j < 5; j++) begin
          e_stall[j] = (j <= s);
          e_flush[j] = (j == s + 1);
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend   <= 1'b0;
      m_tgt    <= '0;
      m_consec <= 0;
      m_to     <= 1'b0;
      m_sc     <= '0;
      m_fc     <= '0;
    end else begin
      if (e_pcr) begin
        m_pend <= 1'b0;
        m_fc   <= m_fc + 1;
      end else if (fl && s >= 2 && !m_pend) begin
        m_pend <= 1'b1;
        m_tgt  <= tgt;
      end
      if (e_stall != 0) begin
        m_sc     <= m_sc + 1;
        m_consec <= m_consec + 1;
        if (m_consec + 1 >= TO) m_to <= 1'b1;
      end else begin
        m_consec <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_stall", {27'd0, stall}, {27'd0, e_stall});
    chk("model_flush", {27'd0, flush}, {27'd0, e_flush});
    chk("model_pcr", {31'd0, pcr}, {31'd0, e_pcr});
    if (e_pcr || !rst_n) chk("model_rpc", rpc, e_pc);
    chk("model_timeout", {31'd0, to}, {31'd0, m_to});
`ifdef CTRL_PERF_CNT_EN
    chk("model_stall_cycles", scyc, m_sc);
    chk("model_flush_count", fcnt, m_fc);
`else
    chk("model_stall_cycles", scyc, 32'd0);
    chk("model_flush_count", fcnt, 32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Held in reset: everything quiet even with requests active.
    id = 1'b1; mem = 1'b1; fl = 1'b1; tgt = 32'h0000_00AA;
    @(negedge clk);
    chk("rst_stall", {27'd0, stall}, 32'd0);
    chk("rst_flush", {27'd0, flush}, 32'd0);
    chk("rst_pcr", {31'd0, pcr}, 32'd0);
    chk("rst_rpc", rpc, 32'd0);
    step();
    id = 1'b0; mem = 1'b0; fl = 1'b0; tgt = '0;
    rst_n = 1'b1;
    step();

    // ID load-use stall only.
    id = 1'b1;
    @(negedge clk);
    chk("id_stall", {27'd0, stall}, 32'h03);
    chk("id_flush", {27'd0, flush}, 32'h04);
    chk("id_pcr", {31'd0, pcr}, 32'd0);

    // MEM wait for three cycles, then release.
    step();
    id = 1'b0; mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mem_stall", {27'd0, stall}, 32'h0F);
      chk("mem_flush", {27'd0, flush}, 32'h10);
      if (i < 2) step();
    end
    step();
    mem = 1'b0;
    @(negedge clk);
    chk("mem_rel_stall", {27'd0, stall}, 32'd0);
    chk("mem_rel_flush", {27'd0, flush}, 32'd0);

    // Redirect overrides a simultaneous ID stall.
    step();
    id = 1'b1; fl = 1'b1; tgt = 32'h0000_1000;
    @(negedge clk);
    chk("redir_pcr", {31'd0, pcr}, 32'd1);
    chk("redir_pc", rpc, 32'h0000_1000);
    chk("redir_flush", {27'd0, flush}, 32'h06);
    chk("redir_stall", {27'd0, stall}, 32'd0);
    step();
    id = 1'b0; fl = 1'b0; tgt = '0;

    // Redirect during EX stall is deferred; a second pulse is dropped.
    step();
    ex = 1'b1; fl = 1'b1; tgt = 32'h0000_2000;
    @(negedge clk);
    chk("pend_pcr0", {31'd0, pcr}, 32'd0);
    chk("pend_stall0", {27'd0, stall}, 32'h07);
    chk("pend_flush0", {27'd0, flush}, 32'h08);
    for (int i = 0; i < 4; i++) begin
      step();
      fl  = (i == 1);
      tgt = (i == 1) ? 32'h0000_3000 : 32'h0;
      @(negedge clk);
      chk("pend_hold_pcr", {31'd0, pcr}, 32'd0);
      chk("pend_hold_stall", {27'd0, stall}, 32'h07);
    end
    step();
    ex = 1'b0; fl = 1'b0; tgt = '0;
    @(negedge clk);
    chk("pend_apply_pcr", {31'd0, pcr}, 32'd1);
    chk("pend_apply_pc", rpc, 32'h0000_2000);
    chk("pend_apply_flush", {27'd0, flush}, 32'h06);
    step();
    @(negedge clk);
    chk("pend_done_pcr", {31'd0, pcr}, 32'd0);

    // Watchdog: 7 stalled cycles stay under the limit, 8 trip it.
    step();
    mem = 1'b1;
    for (int i = 0; i < 6; i++) step();
    step();
    mem = 1'b0;
    @(negedge clk);
    chk("wdt_7_cycles", {31'd0, to}, 32'd0);
    step();
    mem = 1'b1;
    for (int i = 0; i < 7; i++) step();
    step();
    mem = 1'b0;
    @(negedge clk);
    chk("wdt_8_cycles", {31'd0, to}, 32'd1);
    step();
    @(negedge clk);
    chk("wdt_sticky", {31'd0, to}, 32'd1);

    // Reset asserted while a redirect is pending.
    step();
    ex = 1'b1; fl = 1'b1; tgt = 32'h0000_4000;
    step();
    fl = 1'b0; tgt = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {27'd0, stall}, 32'd0);
    chk("midrst_flush", {27'd0, flush}, 32'd0);
    chk("midrst_pcr", {31'd0, pcr}, 32'd0);
    chk("midrst_timeout", {31'd0, to}, 32'd0);
    step();
    step();
    ex = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_pcr", {31'd0, pcr}, 32'd0);
    chk("postrst_stall_cycles", scyc, 32'd0);
    chk("postrst_flush_count", fcnt, 32'd0);
    step();
    @(negedge clk);
    chk("postrst_pcr2", {31'd0, pcr}, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
